// File: rtl/shop_db_v_pkg.sv
// Shared constants for the shop database: command keys, status words,
// FSM states and the decoded command set.
package shop_db_v_pkg;

    localparam int WORD_W = 64;

    localparam logic [WORD_W-1:0] K_LOGIN   = 64'("Login");
    localparam logic [WORD_W-1:0] K_LOGOUT  = 64'("Logout");
    localparam logic [WORD_W-1:0] K_ADDUSR  = 64'("AddUsr");
    localparam logic [WORD_W-1:0] K_DELUSR  = 64'("DelUsr");
    localparam logic [WORD_W-1:0] K_ADDITEM = 64'("AddItem");
    localparam logic [WORD_W-1:0] K_DELITEM = 64'("DelItem");
    localparam logic [WORD_W-1:0] K_BUY     = 64'("Buy");

    localparam logic [WORD_W-1:0] ST_NONE    = 64'("NONE");
    localparam logic [WORD_W-1:0] ST_OK      = 64'("OK");
    localparam logic [WORD_W-1:0] ST_BADCMD  = 64'("BADCMD");
    localparam logic [WORD_W-1:0] ST_BADARG  = 64'("BADARG");
    localparam logic [WORD_W-1:0] ST_DENIED  = 64'("DENIED");
    localparam logic [WORD_W-1:0] ST_NOUSER  = 64'("NOUSER");
    localparam logic [WORD_W-1:0] ST_EXISTS  = 64'("EXISTS");
    localparam logic [WORD_W-1:0] ST_FULL    = 64'("FULL");
    localparam logic [WORD_W-1:0] ST_QTYMAX  = 64'("QTYMAX");
    localparam logic [WORD_W-1:0] ST_NOITEM  = 64'("NOITEM");
    localparam logic [WORD_W-1:0] ST_SOLDOUT = 64'("SOLDOUT");
    localparam logic [WORD_W-1:0] ST_TIMEOUT = 64'("TIMEOUT");

    typedef enum logic [1:0] {S_IDLE, S_ARG, S_SCAN, S_RESP} state_e;

    typedef enum logic [2:0] {
        C_LOGIN, C_LOGOUT, C_ADDUSR, C_DELUSR, C_ADDITEM, C_DELITEM, C_BUY, C_BAD
    } cmd_e;

    function automatic logic is_item_cmd(input cmd_e c);
        return (c == C_ADDITEM) || (c == C_DELITEM) || (c == C_BUY);
    endfunction

endpackage

// File: rtl/shop_db_v_if.sv
// Host-side word bus of the shop database: command/argument in, status out.
interface shop_db_v_if #(
    parameter int A_NUM_CHARS = 8,
    parameter int O_NUM_CHARS = 8,
    parameter int U_NUM_BITS  = 4
);
    logic                       i_rdy;
    logic [U_NUM_BITS-1:0]      i_u;
    logic [A_NUM_CHARS*8-1:0]   i_a;
    logic [O_NUM_CHARS*8-1:0]   o_a;
    logic                       o_vld;
    logic                       o_busy;
    logic [U_NUM_BITS-1:0]      o_cur_user;
    logic                       o_logged_in;

    modport master (output i_rdy, i_u, i_a,
                    input  o_a, o_vld, o_busy, o_cur_user, o_logged_in);
    modport slave  (input  i_rdy, i_u, i_a,
                    output o_a, o_vld, o_busy, o_cur_user, o_logged_in);
endinterface

// File: rtl/shop_db_v_item_tbl.sv
// Item inventory: name/qty/valid slots plus a one-slot-per-cycle scanner that
// records the lowest matching slot and the lowest empty slot.
module shop_item_tbl_v #(
    parameter int NAME_W    = 64,
    parameter int MAX_ITEMS = 8,
    parameter int QTY_BITS  = 8,
    parameter int IDX_W     = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_step,
    input  logic [NAME_W-1:0]   i_name,
    input  logic                i_wr,
    input  logic                i_clr,
    input  logic                i_inc,
    input  logic                i_dec,
    input  logic [IDX_W-1:0]    i_idx,
    output logic                o_last,
    output logic                o_hit,
    output logic [IDX_W-1:0]    o_hit_idx,
    output logic [QTY_BITS-1:0] o_hit_qty,
    output logic                o_free,
    output logic [IDX_W-1:0]    o_free_idx
);
    logic [NAME_W-1:0]   name_q [MAX_ITEMS];
    logic [NAME_W-1:0]   name_d [MAX_ITEMS];
    logic [QTY_BITS-1:0] qty_q  [MAX_ITEMS];
    logic [QTY_BITS-1:0] qty_d  [MAX_ITEMS];
    logic [MAX_ITEMS-1:0] vld_q, vld_d;
    logic [IDX_W-1:0]    idx_q, idx_d, hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
    logic                hit_q, hit_d, free_q, free_d;

    always_comb begin
        name_d     = name_q;
        qty_d      = qty_q;
        vld_d      = vld_q;
        idx_d      = idx_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        free_d     = free_q;
        free_idx_d = free_idx_q;
        if (i_start) begin
            idx_d      = '0;
            hit_d      = 1'b0;
            hit_idx_d  = '0;
            free_d     = 1'b0;
            free_idx_d = '0;
        end else if (i_step) begin
            // First hit / first hole win, so later slots never overwrite them.
            if (vld_q[idx_q] && (name_q[idx_q] == i_name) && !hit_q) begin
                hit_d     = 1'b1;
                hit_idx_d = idx_q;
            end
            if (!vld_q[idx_q] && !free_q) begin
                free_d     = 1'b1;
                free_idx_d = idx_q;
            end
            idx_d = idx_q + IDX_W'(1);
        end
        if (i_wr) begin
            name_d[i_idx] = i_name;
            qty_d[i_idx]  = QTY_BITS'(1);
            vld_d[i_idx]  = 1'b1;
        end
        if (i_clr) vld_d[i_idx] = 1'b0;
        if (i_inc) qty_d[i_idx] = qty_q[i_idx] + QTY_BITS'(1);
        if (i_dec) qty_d[i_idx] = qty_q[i_idx] - QTY_BITS'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q      <= '0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            free_q     <= 1'b0;
            free_idx_q <= '0;
        end else begin
            vld_q      <= vld_d;
            idx_q      <= idx_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            free_q     <= free_d;
            free_idx_q <= free_idx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        name_q <= name_d;
        qty_q  <= qty_d;
    end

    assign o_last     = (idx_q == IDX_W'(MAX_ITEMS - 1));
    assign o_hit      = hit_q;
    assign o_hit_idx  = hit_idx_q;
    assign o_hit_qty  = qty_q[hit_idx_q];
    assign o_free     = free_q;
    assign o_free_idx = free_idx_q;
endmodule

// File: rtl/shop_db_v.sv
// Shop database top: command FSM, user table and argument timeout; the item
// inventory lives in shop_item_tbl_v.
module shop_db_v import shop_db_v_pkg::*; #(
    parameter int A_NUM_CHARS = 8,
    parameter int O_NUM_CHARS = 8,
    parameter int U_NUM_BITS  = 4,
    parameter int MAX_USERS   = 5,
    parameter int MAX_ITEMS   = 8,
    parameter int QTY_BITS    = 8,
    parameter int ARG_TIMEOUT = 255
) (
    input  logic      i_clk,
    input  logic      i_reset,
    shop_db_v_if.slave bus
);
    localparam int A_W    = A_NUM_CHARS * 8;
    localparam int O_W    = O_NUM_CHARS * 8;
    localparam int IDX_W  = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
    localparam int TMO_W  = $clog2(ARG_TIMEOUT + 1);
    localparam int U_SPAN = 2 ** U_NUM_BITS;
    localparam int UW1    = U_NUM_BITS + 1;

    state_e                state_q, state_d;
    cmd_e                  cmd_q, cmd_d, cmd_in;
    logic [WORD_W-1:0]     status_q, status_d;
    logic [A_W-1:0]        name_q, name_d;
    logic                  exec_q, exec_d, rdy_q, rdy_d, logged_q, logged_d, o_vld_q, o_vld_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [U_NUM_BITS-1:0] cur_user_q, cur_user_d;
    logic [MAX_USERS-1:0]  user_vld_q, user_vld_d;
    logic [U_SPAN-1:0]     uvld_ext, uvld_ext_d;
    logic [O_W-1:0]        o_a_q, o_a_d;
    logic                  accept, admin, u_in, u_exists;
    logic                  tbl_start, tbl_step, tbl_wr, tbl_clr, tbl_inc, tbl_dec;
    logic                  tbl_last, tbl_hit, tbl_free;
    logic [IDX_W-1:0]      tbl_idx, tbl_hit_idx, tbl_free_idx;
    logic [QTY_BITS-1:0]   tbl_hit_qty;

    function automatic cmd_e decode_cmd(input logic [A_W-1:0] w);
        if (w == A_W'(K_LOGIN))   return C_LOGIN;
        if (w == A_W'(K_LOGOUT))  return C_LOGOUT;
        if (w == A_W'(K_ADDUSR))  return C_ADDUSR;
        if (w == A_W'(K_DELUSR))  return C_DELUSR;
        if (w == A_W'(K_ADDITEM)) return C_ADDITEM;
        if (w == A_W'(K_DELITEM)) return C_DELITEM;
        if (w == A_W'(K_BUY))     return C_BUY;
        return C_BAD;
    endfunction

    assign rdy_d    = bus.i_rdy;
    assign accept   = bus.i_rdy & ~rdy_q;
    assign admin    = logged_q && (cur_user_q == '0);
    assign cmd_in   = decode_cmd(bus.i_a);
    // Zero-extended user table so any i_u can index it; out-of-range ids read as absent.
    assign uvld_ext = U_SPAN'(user_vld_q);
    assign u_in     = {1'b0, bus.i_u} < UW1'(MAX_USERS);
    assign u_exists = uvld_ext[bus.i_u];

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        status_d   = status_q;
        name_d     = name_q;
        exec_d     = exec_q;
        tmo_d      = tmo_q;
        cur_user_d = cur_user_q;
        logged_d   = logged_q;
        uvld_ext_d = uvld_ext;
        o_a_d      = o_a_q;
        o_vld_d    = 1'b0;
        tbl_start  = 1'b0;
        tbl_step   = 1'b0;
        tbl_wr     = 1'b0;
        tbl_clr    = 1'b0;
        tbl_inc    = 1'b0;
        tbl_dec    = 1'b0;
        tbl_idx    = '0;
        case (state_q)
            S_IDLE: if (accept) begin
                cmd_d  = cmd_in;
                exec_d = 1'b0;
                tmo_d  = '0;
                if (is_item_cmd(cmd_in)) begin
                    state_d = S_ARG;
                end else begin
                    state_d = S_RESP;
                    case (cmd_in)
                        C_LOGIN: begin
                            if (!u_in || !u_exists) status_d = ST_NOUSER;
                            else if (logged_q)      status_d = ST_DENIED;
                            else begin
                                status_d   = ST_OK;
                                cur_user_d = bus.i_u;
                                logged_d   = 1'b1;
                            end
                        end
                        C_LOGOUT: begin
                            status_d = ST_OK;
                            logged_d = 1'b0;
                        end
                        C_ADDUSR: begin
                            if (!admin)        status_d = ST_DENIED;
                            else if (!u_in)    status_d = ST_NOUSER;
                            else if (u_exists) status_d = ST_EXISTS;
                            else begin
                                status_d            = ST_OK;
                                uvld_ext_d[bus.i_u] = 1'b1;
                            end
                        end
                        C_DELUSR: begin
                            if (!admin)                 status_d = ST_DENIED;
                            else if (!u_in)             status_d = ST_NOUSER;
                            else if (bus.i_u == '0)     status_d = ST_DENIED;
                            else if (!u_exists)         status_d = ST_NOUSER;
                            else begin
                                status_d            = ST_OK;
                                uvld_ext_d[bus.i_u] = 1'b0;
                            end
                        end
                        default: status_d = ST_BADCMD;
                    endcase
                end
            end
            S_ARG: begin
                if (accept) begin
                    if (bus.i_a == '0) begin
                        status_d = ST_BADARG;
                        state_d  = S_RESP;
                    end else begin
                        name_d    = bus.i_a;
                        exec_d    = 1'b1;
                        tbl_start = 1'b1;
                        state_d   = S_SCAN;
                    end
                end else if (tmo_q == TMO_W'(ARG_TIMEOUT - 1)) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_SCAN: begin
                tbl_step = 1'b1;
                if (tbl_last) state_d = S_RESP;
            end
            default: begin
                // RESP: publish the status; item commands execute here on the scan result.
                state_d = S_IDLE;
                o_vld_d = 1'b1;
                o_a_d   = O_W'(status_q);
                if (exec_q) begin
                    o_a_d = O_W'(ST_DENIED);
                    case (cmd_q)
                        C_ADDITEM: if (admin) begin
                            if (tbl_hit) begin
                                if (&tbl_hit_qty) o_a_d = O_W'(ST_QTYMAX);
                                else begin
                                    o_a_d   = O_W'(ST_OK);
                                    tbl_inc = 1'b1;
                                    tbl_idx = tbl_hit_idx;
                                end
                            end else if (tbl_free) begin
                                o_a_d   = O_W'(ST_OK);
                                tbl_wr  = 1'b1;
                                tbl_idx = tbl_free_idx;
                            end else o_a_d = O_W'(ST_FULL);
                        end
                        C_DELITEM: if (admin) begin
                            if (tbl_hit) begin
                                o_a_d   = O_W'(ST_OK);
                                tbl_clr = 1'b1;
                                tbl_idx = tbl_hit_idx;
                            end else o_a_d = O_W'(ST_NOITEM);
                        end
                        C_BUY: if (logged_q && (cur_user_q != '0)) begin
                            if (!tbl_hit)                o_a_d = O_W'(ST_NOITEM);
                            else if (tbl_hit_qty == '0)  o_a_d = O_W'(ST_SOLDOUT);
                            else begin
                                o_a_d   = O_W'(ST_OK);
                                tbl_dec = 1'b1;
                                tbl_idx = tbl_hit_idx;
                            end
                        end
                        default: o_a_d = O_W'(ST_DENIED);
                    endcase
                end
            end
        endcase
    end

    assign user_vld_d = uvld_ext_d[MAX_USERS-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b0;
            exec_q     <= 1'b0;
            tmo_q      <= '0;
            cur_user_q <= '0;
            logged_q   <= 1'b0;
            user_vld_q <= MAX_USERS'(1);
            o_a_q      <= O_W'(ST_NONE);
            o_vld_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            exec_q     <= exec_d;
            tmo_q      <= tmo_d;
            cur_user_q <= cur_user_d;
            logged_q   <= logged_d;
            user_vld_q <= user_vld_d;
            o_a_q      <= o_a_d;
            o_vld_q    <= o_vld_d;
        end
    end

    always_ff @(posedge i_clk) begin
        cmd_q    <= cmd_d;
        status_q <= status_d;
        name_q   <= name_d;
    end

    shop_item_tbl_v #(
        .NAME_W    (A_W),
        .MAX_ITEMS (MAX_ITEMS),
        .QTY_BITS  (QTY_BITS),
        .IDX_W     (IDX_W)
    ) u_tbl (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (tbl_start),
        .i_step     (tbl_step),
        .i_name     (name_q),
        .i_wr       (tbl_wr),
        .i_clr      (tbl_clr),
        .i_inc      (tbl_inc),
        .i_dec      (tbl_dec),
        .i_idx      (tbl_idx),
        .o_last     (tbl_last),
        .o_hit      (tbl_hit),
        .o_hit_idx  (tbl_hit_idx),
        .o_hit_qty  (tbl_hit_qty),
        .o_free     (tbl_free),
        .o_free_idx (tbl_free_idx)
    );

    assign bus.o_a         = o_a_q;
    assign bus.o_vld       = o_vld_q;
    assign bus.o_busy      = (state_q != S_IDLE);
    assign bus.o_cur_user  = cur_user_q;
    assign bus.o_logged_in = logged_q;
endmodule

// File: tb/tb_shop_db_v.sv
// Directed bench for shop_db_v; runs with QTY_BITS=2 so quantity saturation is reachable.
module tb_shop_db_v;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    shop_db_v_if #(.A_NUM_CHARS(8), .O_NUM_CHARS(8), .U_NUM_BITS(4)) bus ();

    shop_db_v #(
        .A_NUM_CHARS(8), .O_NUM_CHARS(8), .U_NUM_BITS(4), .MAX_USERS(5),
        .MAX_ITEMS(8), .QTY_BITS(2), .ARG_TIMEOUT(255)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic send_word(input logic [63:0] w, input logic [3:0] u);
        @(posedge i_clk); #1;
        bus.i_a = w; bus.i_u = u; bus.i_rdy = 1'b1;
        @(posedge i_clk); #1;
        bus.i_rdy = 1'b0;
    endtask

    task automatic wait_vld(input int max_cyc, output int lat, output logic [63:0] st);
        lat = -1; st = '0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge i_clk); #1;
            if (bus.o_vld) begin lat = i; st = bus.o_a; break; end
        end
    endtask

    task automatic run_cmd(input logic [63:0] w, input logic [3:0] u, output int lat, output logic [63:0] st);
        send_word(w, u);
        wait_vld(20, lat, st);
    endtask

    task automatic run_item(input logic [63:0] c, input logic [63:0] n, output int lat, output logic [63:0] st);
        send_word(c, 4'd0);
        send_word(n, 4'd0);
        wait_vld(20, lat, st);
    endtask

    task automatic test_reset();
        int lat; logic [63:0] st;
        repeat (3) @(posedge i_clk); #1; i_reset = 1'b0;
        total++; if (bus.o_a !== 64'("NONE")) begin bad++; $display("FAIL reset_o_a got=%s exp=NONE", bus.o_a); end
        total++; if (bus.o_vld !== 1'b0) begin bad++; $display("FAIL reset_o_vld got=%b exp=0", bus.o_vld); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_o_busy got=%b exp=0", bus.o_busy); end
        total++; if (bus.o_cur_user !== 4'd0) begin bad++; $display("FAIL reset_cur_user got=%0d exp=0", bus.o_cur_user); end
        run_cmd(64'("sdfsdf"), 4'd0, lat, st);
        total++; if (st !== 64'("BADCMD")) begin bad++; $display("FAIL badcmd_st got=%s exp=BADCMD", st); end
        total++; if (lat !== 1) begin bad++; $display("FAIL badcmd_lat got=%0d exp=1", lat); end
        @(posedge i_clk); #1;
        total++; if (bus.o_vld !== 1'b0) begin bad++; $display("FAIL vld_pulse got=%b exp=0", bus.o_vld); end
        total++; if (bus.o_logged_in !== 1'b0) begin bad++; $display("FAIL badcmd_logged got=%b exp=0", bus.o_logged_in); end
        total++; if (bus.o_a !== 64'("BADCMD")) begin bad++; $display("FAIL o_a_hold got=%s exp=BADCMD", bus.o_a); end
    endtask

    task automatic test_hold();
        int cnt = 0;
        @(posedge i_clk); #1;
        bus.i_a = 64'("sdfsdf"); bus.i_rdy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge i_clk); #1;
            if (i == 4) bus.i_rdy = 1'b0;
            if (bus.o_vld) cnt++;
        end
        total++; if (cnt !== 1) begin bad++; $display("FAIL hold_one_word got=%0d exp=1", cnt); end
    endtask

    task automatic test_admin_setup();
        int lat; logic [63:0] st;
        run_cmd(64'("Login"), 4'd0, lat, st);
        total++; if (st !== 64'("OK") || lat !== 1) begin bad++; $display("FAIL login_admin got=%s lat=%0d exp=OK lat=1", st, lat); end
        total++; if (bus.o_cur_user !== 4'd0 || bus.o_logged_in !== 1'b1) begin bad++; $display("FAIL login_admin_user got=%0d/%b exp=0/1", bus.o_cur_user, bus.o_logged_in); end
        for (int k = 0; k < 3; k++) begin
            run_item(64'("AddItem"), 64'("pen"), lat, st);
            total++; if (st !== 64'("OK")) begin bad++; $display("FAIL additem_pen%0d got=%s exp=OK", k, st); end
            total++; if (lat !== 9) begin bad++; $display("FAIL additem_lat%0d got=%0d exp=9", k, lat); end
        end
        run_cmd(64'("AddUsr"), 4'd2, lat, st);
        total++; if (st !== 64'("OK")) begin bad++; $display("FAIL addusr2 got=%s exp=OK", st); end
    endtask

    task automatic test_buy();
        int lat; logic [63:0] st;
        run_cmd(64'("Logout"), 4'd0, lat, st);
        total++; if (st !== 64'("OK") || bus.o_logged_in !== 1'b0) begin bad++; $display("FAIL logout got=%s/%b exp=OK/0", st, bus.o_logged_in); end
        run_cmd(64'("Login"), 4'd2, lat, st);
        total++; if (st !== 64'("OK") || bus.o_cur_user !== 4'd2) begin bad++; $display("FAIL login2 got=%s/%0d exp=OK/2", st, bus.o_cur_user); end
        for (int k = 0; k < 3; k++) begin
            run_item(64'("Buy"), 64'("pen"), lat, st);
            total++; if (st !== 64'("OK")) begin bad++; $display("FAIL buy_pen%0d got=%s exp=OK", k, st); end
        end
        run_item(64'("Buy"), 64'("pen"), lat, st);
        total++; if (st !== 64'("SOLDOUT")) begin bad++; $display("FAIL buy_soldout got=%s exp=SOLDOUT", st); end
        run_item(64'("Buy"), 64'("cup"), lat, st);
        total++; if (st !== 64'("NOITEM")) begin bad++; $display("FAIL buy_noitem got=%s exp=NOITEM", st); end
        run_item(64'("AddItem"), 64'("cup"), lat, st);
        total++; if (st !== 64'("DENIED")) begin bad++; $display("FAIL additem_user got=%s exp=DENIED", st); end
        run_item(64'("Buy"), 64'd0, lat, st);
        total++; if (st !== 64'("BADARG") || lat !== 1) begin bad++; $display("FAIL badarg got=%s lat=%0d exp=BADARG lat=1", st, lat); end
    endtask

    task automatic test_resp_drop();
        int cnt = 0; logic [63:0] st = '0;
        send_word(64'("Buy"), 4'd0);
        send_word(64'("cup"), 4'd0);
        repeat (8) @(posedge i_clk); #1;
        bus.i_a = 64'("sdfsdf"); bus.i_rdy = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge i_clk); #1;
            if (i == 3) bus.i_rdy = 1'b0;
            if (bus.o_vld) begin cnt++; st = bus.o_a; end
        end
        total++; if (cnt !== 1) begin bad++; $display("FAIL resp_drop_cnt got=%0d exp=1", cnt); end
        total++; if (st !== 64'("NOITEM")) begin bad++; $display("FAIL resp_drop_st got=%s exp=NOITEM", st); end
    endtask

    task automatic test_timeout_reset();
        int lat; int cnt = 0; logic [63:0] st;
        run_cmd(64'("Logout"), 4'd0, lat, st);
        run_cmd(64'("Login"), 4'd0, lat, st);
        total++; if (st !== 64'("OK")) begin bad++; $display("FAIL relogin_admin got=%s exp=OK", st); end
        send_word(64'("AddItem"), 4'd0);
        total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL busy_arg got=%b exp=1", bus.o_busy); end
        wait_vld(300, lat, st);
        total++; if (st !== 64'("TIMEOUT") || lat !== 256) begin bad++; $display("FAIL timeout got=%s lat=%0d exp=TIMEOUT lat=256", st, lat); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b exp=0", bus.o_busy); end
        send_word(64'("AddItem"), 4'd0);
        send_word(64'("zz"), 4'd0);
        repeat (2) @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge i_clk); #1;
            if (bus.o_vld) cnt++;
        end
        total++; if (cnt !== 0) begin bad++; $display("FAIL scan_reset_vld got=%0d exp=0", cnt); end
        total++; if (bus.o_a !== 64'("NONE")) begin bad++; $display("FAIL scan_reset_o_a got=%s exp=NONE", bus.o_a); end
        total++; if (bus.o_logged_in !== 1'b0 || bus.o_busy !== 1'b0) begin bad++; $display("FAIL scan_reset_state got=%b/%b exp=0/0", bus.o_logged_in, bus.o_busy); end
    endtask

    task automatic test_full();
        int lat; logic [63:0] st; logic [63:0] nm;
        run_cmd(64'("Login"), 4'd2, lat, st);
        total++; if (st !== 64'("NOUSER")) begin bad++; $display("FAIL user_cleared got=%s exp=NOUSER", st); end
        run_cmd(64'("Login"), 4'd0, lat, st);
        run_item(64'("DelItem"), 64'("pen"), lat, st);
        total++; if (st !== 64'("NOITEM")) begin bad++; $display("FAIL items_cleared got=%s exp=NOITEM", st); end
        for (int k = 0; k < 8; k++) begin
            nm = 64'({"it", 8'(8'h30 + k)});
            run_item(64'("AddItem"), nm, lat, st);
            total++; if (st !== 64'("OK")) begin bad++; $display("FAIL fill%0d got=%s exp=OK", k, st); end
        end
        run_item(64'("AddItem"), 64'("it8"), lat, st);
        total++; if (st !== 64'("FULL")) begin bad++; $display("FAIL full got=%s exp=FULL", st); end
        run_item(64'("DelItem"), 64'("it2"), lat, st);
        total++; if (st !== 64'("OK")) begin bad++; $display("FAIL delitem got=%s exp=OK", st); end
        run_item(64'("AddItem"), 64'("it8"), lat, st);
        total++; if (st !== 64'("OK")) begin bad++; $display("FAIL refill got=%s exp=OK", st); end
        total++; if (dut.u_tbl.name_q[2] !== 64'("it8")) begin bad++; $display("FAIL refill_slot2 got=%s exp=it8", dut.u_tbl.name_q[2]); end
    endtask

    task automatic test_qty_users();
        int lat; logic [63:0] st;
        logic [63:0] exp_x [4];
        exp_x = '{64'("OK"), 64'("OK"), 64'("OK"), 64'("QTYMAX")};
        run_item(64'("DelItem"), 64'("it0"), lat, st);
        total++; if (st !== 64'("OK")) begin bad++; $display("FAIL del_it0 got=%s exp=OK", st); end
        for (int k = 0; k < 4; k++) begin
            run_item(64'("AddItem"), 64'("x"), lat, st);
            total++; if (st !== exp_x[k]) begin bad++; $display("FAIL add_x%0d got=%s exp=%s", k, st, exp_x[k]); end
        end
        run_cmd(64'("Login"), 4'd7, lat, st);
        total++; if (st !== 64'("NOUSER")) begin bad++; $display("FAIL login7 got=%s exp=NOUSER", st); end
        run_cmd(64'("DelUsr"), 4'd0, lat, st);
        total++; if (st !== 64'("DENIED")) begin bad++; $display("FAIL delusr0 got=%s exp=DENIED", st); end
        run_cmd(64'("AddUsr"), 4'd5, lat, st);
        total++; if (st !== 64'("NOUSER")) begin bad++; $display("FAIL addusr5 got=%s exp=NOUSER", st); end
        run_cmd(64'("AddUsr"), 4'd0, lat, st);
        total++; if (st !== 64'("EXISTS")) begin bad++; $display("FAIL addusr0 got=%s exp=EXISTS", st); end
        run_cmd(64'("DelUsr"), 4'd3, lat, st);
        total++; if (st !== 64'("NOUSER")) begin bad++; $display("FAIL delusr3_missing got=%s exp=NOUSER", st); end
        run_cmd(64'("AddUsr"), 4'd3, lat, st);
        total++; if (st !== 64'("OK")) begin bad++; $display("FAIL addusr3 got=%s exp=OK", st); end
        run_cmd(64'("DelUsr"), 4'd3, lat, st);
        total++; if (st !== 64'("OK")) begin bad++; $display("FAIL delusr3 got=%s exp=OK", st); end
    endtask

    initial begin
        bus.i_rdy = 1'b0;
        bus.i_a   = '0;
        bus.i_u   = '0;
        test_reset();
        test_hold();
        test_admin_setup();
        test_buy();
        test_resp_drop();
        test_timeout_reset();
        test_full();
        test_qty_users();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
